// File: rtl/reverb_comb_mc.sv
// Multi-channel feedback comb reverb: per-channel circular delay lines share one synchronous RAM.
// Define REVERB_DAMP_EN to place a one-pole lowpass in each channel's feedback path.

module reverb_comb_mc #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned GAIN_W = 5
) (
    input  logic                       clk,
    input  logic                       ce,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [ADDR_W-1:0]          delay_samples,
    input  logic [GAIN_W-1:0]          feedback_gain,
    input  logic [GAIN_W:0]            wet_dry_mix,
    output logic                       out_valid,
    output logic [NUM_CH*DATA_W-1:0]   out_data
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned RAM_AW    = CH_W + ADDR_W;
    localparam int unsigned RAM_WORDS = NUM_CH * DEPTH;
    localparam int unsigned PW        = DATA_W + GAIN_W + 2;
    localparam int unsigned UNITY     = 1 << GAIN_W;
    localparam int unsigned FRAME_W   = NUM_CH * DATA_W;

    localparam logic signed [PW-1:0] SAT_HI = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [RAM_AW-1:0]          r_clr_cnt;
    logic [ADDR_W-1:0]          r_wr_ptr;
    logic [CH_W-1:0]            r_ch;
    logic [FRAME_W-1:0]         r_x;
    logic [ADDR_W-1:0]          r_delay;
    logic [GAIN_W-1:0]          r_gain;
    logic [GAIN_W:0]            r_mix;
    logic                       r_in_ready;
    logic                       r_out_valid;
    logic [FRAME_W-1:0]         r_out_data;
    logic [FRAME_W-1:0]         r_y_shadow;
    logic signed [DATA_W-1:0]   r_buf_in;
    logic signed [DATA_W-1:0]   r_y;

    logic [DATA_W-1:0]          r_ram [RAM_WORDS];
    logic signed [DATA_W-1:0]   r_ram_q;

    logic                       w_accept;
    logic                       w_last_ch;
    logic                       w_clr_last;
    logic [ADDR_W-1:0]          w_rd_ptr;
    logic                       w_ram_we;
    logic [RAM_AW-1:0]          w_ram_waddr;
    logic [RAM_AW-1:0]          w_ram_raddr;
    logic [DATA_W-1:0]          w_ram_wdata;

    logic signed [DATA_W-1:0]   w_x;
    logic signed [DATA_W-1:0]   w_wet;
    logic signed [DATA_W-1:0]   w_fb_src;
    logic signed [PW-1:0]       w_x_ext;
    logic signed [PW-1:0]       w_wet_ext;
    logic signed [PW-1:0]       w_g_ext;
    logic signed [PW-1:0]       w_m_ext;
    logic signed [PW-1:0]       w_dry_ext;
    logic signed [PW-1:0]       w_fb;
    logic signed [PW-1:0]       w_sum_fb;
    logic signed [PW-1:0]       w_mix_sum;
    logic signed [PW-1:0]       w_mix_sh;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[DATA_W-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    assign w_accept   = in_valid & r_in_ready;
    assign w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));
    assign w_clr_last = (r_clr_cnt == RAM_AW'(RAM_WORDS - 1));
    assign w_rd_ptr   = r_wr_ptr - r_delay;

    // Next-state and RAM port control
    always_comb begin
        w_state_next = r_state;
        w_ram_we     = 1'b0;
        w_ram_waddr  = r_clr_cnt;
        w_ram_wdata  = '0;
        w_ram_raddr  = {r_ch, w_rd_ptr};
        case (r_state)
            S_CLEAR: begin
                w_ram_we = 1'b1;
                if (w_clr_last) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_READ;
                end
            end
            S_READ:  w_state_next = S_CALC;
            S_CALC:  w_state_next = S_WRITE;
            S_WRITE: begin
                w_ram_we     = 1'b1;
                w_ram_waddr  = {r_ch, r_wr_ptr};
                w_ram_wdata  = r_buf_in;
                w_state_next = w_last_ch ? S_DONE : S_READ;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge ce) begin
        if (!ce) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Delay-line storage; contents are initialised by the CLEAR sweep, not by reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_waddr] <= w_ram_wdata;
        end
        r_ram_q <= r_ram[w_ram_raddr];
    end

    assign w_x       = r_x[r_ch*DATA_W +: DATA_W];
    assign w_wet     = r_ram_q;
    assign w_x_ext   = PW'(w_x);
    assign w_wet_ext = PW'(w_wet);
    assign w_g_ext   = PW'(r_gain);
    assign w_m_ext   = PW'(r_mix);
    assign w_dry_ext = PW'(UNITY) - w_m_ext;

`ifdef REVERB_DAMP_EN
    logic signed [DATA_W-1:0] r_lp [NUM_CH];
    logic signed [DATA_W-1:0] w_lp_cur;
    logic signed [DATA_W:0]   w_lp_diff;
    logic signed [DATA_W-1:0] w_lp_next;

    assign w_lp_cur  = r_lp[r_ch];
    assign w_lp_diff = (DATA_W+1)'(w_wet) - (DATA_W+1)'(w_lp_cur);
    assign w_lp_next = w_lp_cur + DATA_W'(w_lp_diff >>> 2);
    // Feedback takes the freshly updated lowpass state of this frame
    assign w_fb_src  = w_lp_next;

    always_ff @(posedge clk or negedge ce) begin
        if (!ce) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_lp[i] <= '0;
            end
        end else if (r_state == S_CLEAR) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_lp[i] <= '0;
            end
        end else if (r_state == S_CALC) begin
            r_lp[r_ch] <= w_lp_next;
        end
    end
`else
    assign w_fb_src  = w_wet;
`endif

    assign w_fb      = (PW'(w_fb_src) * w_g_ext) >>> GAIN_W;
    assign w_sum_fb  = w_x_ext + w_fb;
    assign w_mix_sum = (w_x_ext * w_dry_ext) + (w_wet_ext * w_m_ext);
    assign w_mix_sh  = w_mix_sum >>> GAIN_W;

    // Frame latch, channel sequencing and output registers
    always_ff @(posedge clk or negedge ce) begin
        if (!ce) begin
            r_clr_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_ch        <= '0;
            r_x         <= '0;
            r_delay     <= ADDR_W'(1);
            r_gain      <= '0;
            r_mix       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_y_shadow  <= '0;
            r_buf_in    <= '0;
            r_y         <= '0;
        end else begin
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (r_state == S_DONE);
            case (r_state)
                S_CLEAR: r_clr_cnt <= r_clr_cnt + RAM_AW'(1);
                S_IDLE: begin
                    if (w_accept) begin
                        r_x    <= in_data;
                        r_ch   <= '0;
                        r_gain <= feedback_gain;
                        // Zero delay means one frame; the port width already caps it at DEPTH-1
                        r_delay <= (delay_samples == '0) ? ADDR_W'(1) : delay_samples;
                        r_mix   <= (wet_dry_mix > (GAIN_W+1)'(UNITY)) ?
                                   (GAIN_W+1)'(UNITY) : wet_dry_mix;
                    end
                end
                S_CALC: begin
                    r_buf_in <= sat(w_sum_fb);
                    r_y      <= sat(w_mix_sh);
                end
                S_WRITE: begin
                    r_y_shadow[r_ch*DATA_W +: DATA_W] <= r_y;
                    r_ch <= r_ch + CH_W'(1);
                end
                S_DONE: begin
                    r_out_data <= r_y_shadow;
                    r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_reverb_comb_mc.sv
// Self-checking bench for reverb_comb_mc: directed scenarios plus randomized frames
// compared against a frame-history reference model.

module tb_reverb_comb_mc;

    localparam int DW = 16;
    localparam int NC = 2;
    localparam int AW = 4;
    localparam int GW = 5;

    logic               clk = 1'b0;
    logic               ce;
    logic               in_valid;
    logic               in_ready;
    logic [NC*DW-1:0]   in_data;
    logic [AW-1:0]      delay_samples;
    logic [GW-1:0]      feedback_gain;
    logic [GW:0]        wet_dry_mix;
    logic               out_valid;
    logic [NC*DW-1:0]   out_data;

    int n_pass  = 0;
    int n_total = 0;
    int hist0[$];
    int hist1[$];

    always #5 clk = ~clk;

    reverb_comb_mc #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW), .GAIN_W(GW)) dut (
        .clk           (clk),
        .ce            (ce),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .delay_samples (delay_samples),
        .feedback_gain (feedback_gain),
        .wet_dry_mix   (wet_dry_mix),
        .out_valid     (out_valid),
        .out_data      (out_data)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int rnd_sample();
        logic [15:0] r;
        r = 16'($urandom);
        return $signed(r);
    endfunction

    function automatic int ch_out(input int c);
        logic [15:0] s;
        s = out_data[c*DW +: DW];
        return $signed(s);
    endfunction

    // Echo model: each channel's wet input is the value it stored D frames ago (0 before that)
    function automatic void model_step(input int x0, input int x1, input int d, input int g,
                                       input int m, output int e0, output int e1);
        int dd, mm, n, x, wet, fb, bufv, y;
        dd = (d == 0) ? 1 : ((d > 15) ? 15 : d);
        mm = (m > 32) ? 32 : m;
        n  = hist0.size();
        e0 = 0;
        e1 = 0;
        for (int ch = 0; ch < 2; ch++) begin
            x   = (ch == 0) ? x0 : x1;
            wet = 0;
            if (n >= dd) wet = (ch == 0) ? hist0[n-dd] : hist1[n-dd];
            fb   = (wet * g) >>> 5;
            bufv = sat16(x + fb);
            y    = sat16((x * (32 - mm) + wet * mm) >>> 5);
            if (ch == 0) begin
                hist0.push_back(bufv);
                e0 = y;
            end else begin
                hist1.push_back(bufv);
                e1 = y;
            end
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        ce = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        ce = 1'b1;
        repeat (32) @(negedge clk);
        hist0.delete();
        hist1.delete();
    endtask

    task automatic do_frame(input int x0, input int x1, input int d, input int g, input int m,
                            output int y0, output int y1);
        int t, lat, e0, e1;
        y0 = 0;
        y1 = 0;
        t  = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
            return;
        end
        n_pass++;
        in_data       = {16'(x1), 16'(x0)};
        delay_samples = 4'(d);
        feedback_gain = 5'(g);
        wet_dry_mix   = 6'(m);
        in_valid      = 1'b1;
        @(negedge clk);
        in_valid      = 1'b0;
        in_data       = $urandom;
        delay_samples = 4'($urandom);
        feedback_gain = 5'($urandom);
        wet_dry_mix   = 6'($urandom);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL ready_drop: in_ready=%b required 0", in_ready);
        else n_pass++;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_total++;
        if (lat !== 7) $display("FAIL latency: got %0d edges required 7", lat);
        else n_pass++;
        model_step(x0, x1, d, g, m, e0, e1);
        y0 = ch_out(0);
        y1 = ch_out(1);
        n_total++;
        if (y0 !== e0) $display("FAIL frame_ch0 @%0t: got %0d required %0d", $time, y0, e0);
        else n_pass++;
        n_total++;
        if (y1 !== e1) $display("FAIL frame_ch1 @%0t: got %0d required %0d", $time, y1, e1);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL pulse_width: out_valid=%b required 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        int highs;
        ce = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        delay_samples = '0;
        feedback_gain = '0;
        wet_dry_mix = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b required 0", in_ready);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== '0) $display("FAIL rst_data: got %h required 0", out_data);
        else n_pass++;
        ce = 1'b1;
        highs = 0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) highs++;
        end
        n_total++;
        if (highs !== 0) $display("FAIL clear_ready_low: got %0d ready cycles required 0", highs);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL clear_done: in_ready=%b required 1", in_ready);
        else n_pass++;
        n_total++;
        if (out_data !== '0) $display("FAIL clear_data: got %h required 0", out_data);
        else n_pass++;
    endtask

    task automatic test_echo();
        int y0, y1, exp0;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            do_frame((k == 0) ? 1000 : 0, 0, 3, 0, 16, y0, y1);
            exp0 = (k == 0 || k == 3) ? 500 : 0;
            n_total++;
            if (y0 !== exp0) $display("FAIL echo_ch0 k=%0d: got %0d required %0d", k, y0, exp0);
            else n_pass++;
            n_total++;
            if (y1 !== 0) $display("FAIL echo_ch1 k=%0d: got %0d required 0", k, y1);
            else n_pass++;
        end
    endtask

    task automatic test_feedback();
        int y0, y1, exp1;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            do_frame(0, (k == 0) ? 1024 : 0, 2, 16, 32, y0, y1);
            exp1 = (k >= 2 && k <= 8 && (k % 2) == 0) ? (1024 >> (k/2 - 1)) : 0;
            n_total++;
            if (y1 !== exp1) $display("FAIL fb_ch1 k=%0d: got %0d required %0d", k, y1, exp1);
            else n_pass++;
            n_total++;
            if (y0 !== 0) $display("FAIL fb_ch0 k=%0d: got %0d required 0", k, y0);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int y0, y1;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            do_frame(30000, -30000, 1, 31, 16, y0, y1);
            if (k == 2) begin
                n_total++;
                if (y0 !== 31383) $display("FAIL sat_pos: got %0d required 31383", y0);
                else n_pass++;
                n_total++;
                if (y1 !== -31384) $display("FAIL sat_neg: got %0d required -31384", y1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_clamp_wrap();
        int y0, y1, exp0;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            do_frame((k == 0) ? 777 : 0, (k == 0) ? -555 : 0, 0, 0, 32, y0, y1);
            if (k == 1) begin
                n_total++;
                if (y0 !== 777 || y1 !== -555)
                    $display("FAIL delay0: got %0d/%0d required 777/-555", y0, y1);
                else n_pass++;
            end
        end
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            do_frame((k == 0) ? 4321 : 0, 0, 15, 0, 32, y0, y1);
            exp0 = (k == 15) ? 4321 : 0;
            n_total++;
            if (y0 !== exp0) $display("FAIL delay15 k=%0d: got %0d required %0d", k, y0, exp0);
            else n_pass++;
        end
        for (int k = 0; k < 40; k++) begin
            do_frame(rnd_sample(), rnd_sample(), 7, 20, 24, y0, y1);
        end
    endtask

    task automatic test_handshake();
        int accepts, seen, extra, lows, e0, e1, y0, y1;
        apply_reset();
        in_data       = {16'(0), 16'(3000)};
        delay_samples = 4'(1);
        feedback_gain = 5'(8);
        wet_dry_mix   = 6'(32);
        in_valid      = 1'b1;
        accepts = 0;
        seen    = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            if (out_valid === 1'b1) begin
                seen = 1;
                in_valid = 1'b0;
                model_step(3000, 0, 1, 8, 32, e0, e1);
                n_total++;
                if (ch_out(0) !== e0) $display("FAIL hold_out: got %0d required %0d", ch_out(0), e0);
                else n_pass++;
            end else begin
                if (in_valid === 1'b1 && in_ready === 1'b1) accepts++;
                @(negedge clk);
            end
        end
        n_total++;
        if (seen !== 1 || accepts !== 1)
            $display("FAIL hold_accepts: got %0d accepts (seen=%0d) required 1", accepts, seen);
        else n_pass++;
        extra = 0;
        lows  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) extra++;
            if (in_ready !== 1'b1) lows++;
        end
        n_total++;
        if (extra !== 0 || lows !== 0)
            $display("FAIL hold_idle: got %0d pulses %0d busy required 0 0", extra, lows);
        else n_pass++;
        do_frame(0, 0, 1, 8, 32, y0, y1);
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int outs[$];
        int e0, e1, x0, x1;
        apply_reset();
        x0 = rnd_sample();
        x1 = rnd_sample();
        in_data       = {16'(x1), 16'(x0)};
        delay_samples = 4'(1);
        feedback_gain = 5'(24);
        wet_dry_mix   = 6'(20);
        in_valid      = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            if (out_valid === 1'b1) begin
                outs.push_back(i);
                model_step(x0, x1, 1, 24, 20, e0, e1);
                n_total++;
                if (ch_out(0) !== e0 || ch_out(1) !== e1)
                    $display("FAIL b2b_data i=%0d: got %0d/%0d required %0d/%0d",
                             i, ch_out(0), ch_out(1), e0, e1);
                else n_pass++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) acc.push_back(i);
            if (i == 33) in_valid = 1'b0;
            @(negedge clk);
        end
        n_total++;
        if (acc.size() !== 5 || outs.size() !== 5)
            $display("FAIL b2b_count: got %0d accepts %0d outputs required 5 5", acc.size(), outs.size());
        else n_pass++;
        for (int k = 0; k < 5 && k < acc.size() && k < outs.size(); k++) begin
            n_total++;
            if (acc[k] !== 8*k || outs[k] !== 8*k + 8)
                $display("FAIL b2b_timing k=%0d: got accept %0d out %0d required %0d %0d",
                         k, acc[k], outs[k], 8*k, 8*k + 8);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int y0, y1, pulses, highs, exp1;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            do_frame(rnd_sample(), rnd_sample(), 2, 16, 32, y0, y1);
        end
        in_data       = {16'(0), 16'(2000)};
        delay_samples = 4'(2);
        feedback_gain = 5'(16);
        wet_dry_mix   = 6'(32);
        in_valid      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        ce = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL abort_outputs: got ready=%b valid=%b required 0 0", in_ready, out_valid);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) pulses++;
        end
        ce = 1'b1;
        hist0.delete();
        hist1.delete();
        highs = 0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) highs++;
            if (out_valid !== 1'b0) pulses++;
        end
        n_total++;
        if (pulses !== 0 || highs !== 0)
            $display("FAIL abort_clear: got %0d pulses %0d ready required 0 0", pulses, highs);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL abort_ready: got %b required 1", in_ready);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            do_frame(0, (k == 0) ? 1500 : 0, 2, 16, 32, y0, y1);
            exp1 = (k == 2) ? 1500 : ((k == 4) ? 750 : 0);
            n_total++;
            if (y0 !== 0 || y1 !== exp1)
                $display("FAIL stale_echo k=%0d: got %0d/%0d required 0/%0d", k, y0, y1, exp1);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int y0, y1;
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            do_frame(rnd_sample(), rnd_sample(), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), y0, y1);
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_feedback();
        test_saturation();
        test_clamp_wrap();
        test_handshake();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
